frame_sync_lock: RTL and testbench
==================================

FRAME_SYNC_LOCK -- requirements
Module: frame_sync_lock

Interface
REQ-001 SHALL have parameter SYNC_MARKER, default 32'h1ACFFC1D, attached sync marker; MSB is sent first.
REQ-002 SHALL have parameter MARKER_BYTES, default 4, marker length in bytes (1..8); SYNC_MARKER is MARKER_BYTES*8 bits wide.
REQ-003 SHALL have parameter CODEWORD_LEN, default 255, data bytes per frame (1..65535).
REQ-004 SHALL have parameter MAX_ERR, default 0, maximum bit mismatches accepted in a marker match.
REQ-005 SHALL have parameter VERIFY_CNT, default 2, consecutive expected-position matches needed to lock (1..15).
REQ-006 SHALL have parameter FLYWHEEL, default 3, consecutive expected-position misses that drop lock (1..15).
REQ-007 SHALL have parameter INVERT_EN, default 1, enables detection of the inverted marker.
REQ-008 SHALL have port core_clk, input, 1, clock.
REQ-009 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-010 SHALL have ports s_axis_tdata, tvalid and tready: in 8, in 1 and out 1; the input byte stream.
REQ-011 SHALL have ports m_axis_tdata, tvalid, tlast and tready: out 8, out 1, out 1 and in 1; the codeword output.
REQ-012 SHALL have ports locked (out 1) for LOCK state, inverted (out 1) for locked polarity, and sync_loss (out 1) for a one-cycle lock-drop pulse.

Function
REQ-013 SHALL count an input byte as accepted when s_axis_tvalid and s_axis_tready are both high; all state advances on accepted bytes only.
REQ-014 SHALL drive s_axis_tready = !m_axis_tvalid || m_axis_tready in every state.
REQ-015 SHALL shift each accepted byte into a MARKER_BYTES-deep window, newest byte in the LSBs, including the byte accepted in the current cycle.
REQ-016 SHALL declare a normal match when the Hamming distance between window and SYNC_MARKER is at most MAX_ERR.
REQ-017 SHALL declare an inverted match when INVERT_EN=1 and the distance to ~SYNC_MARKER is at most MAX_ERR.
REQ-018 SHALL give a normal match priority over an inverted match.
REQ-019 SHALL implement states SEARCH, VERIFY and LOCK; reset state is SEARCH.
REQ-020 SEARCH: SHALL test for a match on every accepted byte once MARKER_BYTES bytes have been accepted since reset.
REQ-021 SEARCH: on a match, SHALL latch the polarity and start the frame position counter at 0.
REQ-022 SEARCH: on a match, SHALL go to LOCK if VERIFY_CNT=1, otherwise go to VERIFY with verify count 1.
REQ-023 SHALL define a frame, after a marker, as CODEWORD_LEN data bytes followed by MARKER_BYTES marker bytes; the expected position is the last marker byte, where the position counter wraps to 0.
REQ-024 VERIFY: SHALL output nothing; at the expected position, a match of the latched polarity increments the verify count; reaching VERIFY_CNT goes to LOCK.
REQ-025 VERIFY: any miss at the expected position SHALL go to SEARCH with no sync_loss pulse.
REQ-026 LOCK: SHALL output every data byte at positions 0..CODEWORD_LEN-1, XORed with 8'hFF when inverted=1; marker bytes are never output.
REQ-027 LOCK: at the expected position, a match of the latched polarity SHALL clear the miss count; a miss SHALL increment it and frame output continues (flywheel).
REQ-028 LOCK: when the miss count reaches FLYWHEEL, SHALL go to SEARCH and pulse sync_loss for one cycle.
REQ-029 SHALL register the output stage: m_axis_tvalid rises the cycle after a data byte is accepted (latency 1), and tdata is held stable while tvalid && !tready.
REQ-030 SHALL assert m_axis_tlast with the byte at position CODEWORD_LEN-1.
REQ-031 A byte accepted into the output stage SHALL still be delivered if lock drops afterwards.
REQ-032 SHALL size the position counter at $clog2(CODEWORD_LEN+MARKER_BYTES+1) bits, with saturating 4-bit verify and miss counters.
REQ-033 SHALL assert locked when state=LOCK; inverted holds the latched polarity and is 0 in SEARCH.
REQ-034 SHALL never clear the window on a return to SEARCH, so a marker overlapping the failed frame is still found.

Reset
REQ-035 On rst, SHALL asynchronously set state=SEARCH, window, all counters, accepted-byte count and m_axis_tdata to 0.
REQ-036 On rst, SHALL drive m_axis_tvalid, m_axis_tlast, locked, inverted and sync_loss to 0, and s_axis_tready to 1.
REQ-037 Reset mid-frame SHALL discard the partial frame with no tlast emitted.

Verification
REQ-038 With CODEWORD_LEN=4 and VERIFY_CNT=2, feed 1A CF FC 1D 01 02 03 04 1A CF FC 1D 05 06 07 08; SHALL assert locked after the second 1D and output 05 06 07 08 with tlast on 08.
REQ-039 Feed ~marker E5 30 03 E2 twice, data 0F F0 00 FF after the second; SHALL assert inverted=1 and output F0 0F FF 00.
REQ-040 With FLYWHEEL=3 while locked, corrupt 2 markers then 1 good one, then corrupt 3; SHALL stay locked through the first two misses, pulse sync_loss one cycle after the 3rd consecutive miss, and return to SEARCH.
REQ-041 With MAX_ERR=1, a marker of 1ACFFC1C SHALL match; 1ACFFC1E (2 bit errors) SHALL not match.
REQ-042 Hold m_axis_tready=0 for 5 cycles while locked; s_axis_tready SHALL drop, tdata SHALL stay stable, and no byte SHALL be lost or duplicated.
REQ-043 Assert rst at position 2 of a locked frame; all outputs SHALL be 0 next cycle with no tlast, and relock SHALL need VERIFY_CNT fresh markers.

Source files
------------

// File: rtl/frame_sync_lock.sv
// Frame synchroniser: hunts for an attached sync marker (normal or inverted) in a byte
// stream, verifies it over several frames, then streams out codeword bytes with flywheel.
module frame_sync_lock #(
  parameter int                          MARKER_BYTES = 4,
  parameter logic [MARKER_BYTES*8-1:0]   SYNC_MARKER  = 32'h1ACFFC1D,
  parameter int                          CODEWORD_LEN = 255,
  parameter int                          MAX_ERR      = 0,
  parameter int                          VERIFY_CNT   = 2,
  parameter int                          FLYWHEEL     = 3,
  parameter bit                          INVERT_EN    = 1'b1
) (
  input  logic       core_clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  input  logic       m_axis_tready,
  output logic       locked,
  output logic       inverted,
  output logic       sync_loss
);

  localparam int             MW        = MARKER_BYTES * 8;
  localparam int             FRAME_LEN = CODEWORD_LEN + MARKER_BYTES;
  localparam int             PW        = $clog2(FRAME_LEN + 1);
  localparam logic [PW-1:0]  LAST_POS  = PW'(FRAME_LEN - 1);
  localparam logic [PW-1:0]  DATA_END  = PW'(CODEWORD_LEN);
  localparam logic [PW-1:0]  TLAST_POS = PW'(CODEWORD_LEN - 1);
  localparam logic [6:0]     MAX_E     = 7'(MAX_ERR);
  localparam logic [3:0]     VCNT_TGT  = 4'(VERIFY_CNT);
  localparam logic [3:0]     MISS_TGT  = 4'(FLYWHEEL);
  localparam logic [3:0]     ARM_CNT   = 4'(MARKER_BYTES - 1);
  localparam logic [3:0]     FULL_CNT  = 4'(MARKER_BYTES);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCK} state_t;

  function automatic logic [6:0] ham_dist(input logic [MW-1:0] a, input logic [MW-1:0] b);
    logic [MW-1:0] x;
    logic [6:0]    cnt;
    x   = a ^ b;
    cnt = '0;
    for (int i = 0; i < MW; i++) cnt = cnt + 7'(x[i]);
    return cnt;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? 4'hF : v + 4'd1;
  endfunction

  state_t        state_q, state_d;
  logic [MW-1:0] win_q, win_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [3:0]    vcnt_q, vcnt_d;
  logic [3:0]    miss_q, miss_d;
  logic          inv_q, inv_d;
  logic          locked_q, locked_d;
  logic          sync_loss_q, sync_loss_d;
  logic [7:0]    tdata_q, tdata_d;
  logic          tvalid_q, tvalid_d;
  logic          tlast_q, tlast_d;

  logic          accept;
  logic [MW-1:0] win_next;
  logic          match_norm, match_inv, hit_any, hit_pol;

  assign s_axis_tready = !tvalid_q || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  // Window includes the byte being accepted this cycle, so a match is seen on its last byte.
  assign win_next      = MW'({win_q, s_axis_tdata});
  assign match_norm    = ham_dist(win_next, SYNC_MARKER) <= MAX_E;
  assign match_inv     = INVERT_EN && (ham_dist(win_next, ~SYNC_MARKER) <= MAX_E);
  assign hit_any       = match_norm || match_inv;
  assign hit_pol       = inv_q ? match_inv : match_norm;

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    cnt_d       = cnt_q;
    pos_d       = pos_q;
    vcnt_d      = vcnt_q;
    miss_d      = miss_q;
    inv_d       = inv_q;
    sync_loss_d = 1'b0;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;

    if (m_axis_tready) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end

    if (accept) begin
      win_d = win_next;
      if (cnt_q < FULL_CNT) cnt_d = cnt_q + 4'd1;
      unique case (state_q)
        SEARCH: begin
          if (cnt_q >= ARM_CNT && hit_any) begin
            inv_d   = !match_norm;
            pos_d   = '0;
            vcnt_d  = 4'd1;
            miss_d  = '0;
            state_d = (VCNT_TGT == 4'd1) ? LOCK : VERIFY;
          end
        end
        VERIFY: begin
          if (pos_q == LAST_POS) begin
            pos_d = '0;
            if (hit_pol) begin
              vcnt_d = sat_inc(vcnt_q);
              if (sat_inc(vcnt_q) >= VCNT_TGT) begin
                state_d = LOCK;
                miss_d  = '0;
              end
            end else begin
              state_d = SEARCH;
              inv_d   = 1'b0;
              vcnt_d  = '0;
            end
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end
        LOCK: begin
          if (pos_q < DATA_END) begin
            tvalid_d = 1'b1;
            tdata_d  = s_axis_tdata ^ {8{inv_q}};
            tlast_d  = (pos_q == TLAST_POS);
            pos_d    = pos_q + 1'b1;
          end else if (pos_q == LAST_POS) begin
            pos_d = '0;
            if (hit_pol) begin
              miss_d = '0;
            end else if (sat_inc(miss_q) >= MISS_TGT) begin
              state_d     = SEARCH;
              inv_d       = 1'b0;
              miss_d      = '0;
              vcnt_d      = '0;
              sync_loss_d = 1'b1;
            end else begin
              miss_d = sat_inc(miss_q);
            end
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    locked_d = (state_d == LOCK);
  end

  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      state_q     <= SEARCH;
      win_q       <= '0;
      cnt_q       <= '0;
      pos_q       <= '0;
      vcnt_q      <= '0;
      miss_q      <= '0;
      inv_q       <= 1'b0;
      locked_q    <= 1'b0;
      sync_loss_q <= 1'b0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      cnt_q       <= cnt_d;
      pos_q       <= pos_d;
      vcnt_q      <= vcnt_d;
      miss_q      <= miss_d;
      inv_q       <= inv_d;
      locked_q    <= locked_d;
      sync_loss_q <= sync_loss_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign locked        = locked_q;
  assign inverted      = inv_q;
  assign sync_loss     = sync_loss_q;

endmodule

// File: tb/tb_frame_sync_lock.sv
// Bench for frame_sync_lock: directed byte stream, expected output bytes queued by the
// stimulus and consumed by an independent output monitor.
module tb_frame_sync_lock;

  logic       core_clk;
  logic       rst;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tlast;
  logic       m_axis_tready;
  logic       locked;
  logic       inverted;
  logic       sync_loss;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];
  logic [8:0] exp_v;

  frame_sync_lock #(
    .CODEWORD_LEN(4),
    .MAX_ERR     (1),
    .VERIFY_CNT  (2),
    .FLYWHEEL    (3)
  ) dut (
    .core_clk     (core_clk),
    .rst          (rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .locked       (locked),
    .inverted     (inverted),
    .sync_loss    (sync_loss)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives one byte and returns one step after the clock edge that accepted it.
  task automatic send(input logic [7:0] b, input bit out, input logic [7:0] ev, input bit el);
    int n;
    n = 0;
    if (out) exp_q.push_back({el, ev});
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    forever begin
      @(negedge core_clk);
      if (s_axis_tready) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: byte %0h not accepted in 50 cycles", b);
        s_axis_tvalid = 1'b0;
        return;
      end
    end
    @(posedge core_clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_mark(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int i = 3; i >= 0; i--) send(t[i*8 +: 8], 1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_quiet(input logic [31:0] w);
    send_mark(w);
  endtask

  always @(negedge core_clk) begin
    if (!rst && m_axis_tvalid && m_axis_tready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got %0h last %0b, nothing expected", m_axis_tdata, m_axis_tlast);
      end else begin
        exp_v = exp_q.pop_front();
        if ({m_axis_tlast, m_axis_tdata} !== exp_v) begin
          errors++;
          $display("FAIL out_byte: got last %0b data %0h, expected last %0b data %0h",
                   m_axis_tlast, m_axis_tdata, exp_v[8], exp_v[7:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    s_axis_tdata  = 8'h00;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge core_clk);
    #1;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_locked", locked, 0);
    check("rst_inverted", inverted, 0);
    check("rst_sync_loss", sync_loss, 0);
    check("rst_s_tready", s_axis_tready, 1);
    rst = 1'b0;

    // Two normal markers four data bytes apart: lock, then pass the next codeword.
    send_mark(32'h1ACFFC1D);
    check("verify_not_locked", locked, 0);
    send_quiet(32'h01020304);
    check("verify_no_output", m_axis_tvalid, 0);
    send_mark(32'h1ACFFC1D);
    check("lock_normal", locked, 1);
    check("lock_normal_pol", inverted, 0);
    send(8'h05, 1, 8'h05, 0);
    send(8'h06, 1, 8'h06, 0);
    send(8'h07, 1, 8'h07, 0);
    send(8'h08, 1, 8'h08, 1);

    // Flywheel: two misses, a good marker, then three misses.
    send_mark(32'h00000000);
    check("fly_miss1_locked", locked, 1);
    for (int i = 0; i < 4; i++) send(8'h11 + 8'(i), 1, 8'h11 + 8'(i), i == 3);
    send_mark(32'h00000000);
    check("fly_miss2_locked", locked, 1);
    for (int i = 0; i < 4; i++) send(8'h21 + 8'(i), 1, 8'h21 + 8'(i), i == 3);
    send_mark(32'h1ACFFC1D);
    for (int i = 0; i < 4; i++) send(8'h31 + 8'(i), 1, 8'h31 + 8'(i), i == 3);
    send_mark(32'h00000000);
    for (int i = 0; i < 4; i++) send(8'h41 + 8'(i), 1, 8'h41 + 8'(i), i == 3);
    send_mark(32'h00000000);
    check("fly_miss2b_locked", locked, 1);
    check("fly_miss2b_no_loss", sync_loss, 0);
    for (int i = 0; i < 4; i++) send(8'h51 + 8'(i), 1, 8'h51 + 8'(i), i == 3);
    send_mark(32'h00000000);
    check("fly_loss_pulse", sync_loss, 1);
    check("fly_loss_unlocked", locked, 0);
    @(posedge core_clk);
    #1;
    check("fly_loss_one_cycle", sync_loss, 0);

    // Inverted marker twice: lock with inverted polarity, output bytes complemented.
    send_mark(32'hE53003E2);
    check("inv_verify_not_locked", locked, 0);
    send_quiet(32'hAABBCCDD);
    send_mark(32'hE53003E2);
    check("inv_locked", locked, 1);
    check("inv_polarity", inverted, 1);
    send(8'h0F, 1, 8'hF0, 0);
    send(8'hF0, 1, 8'h0F, 0);
    send(8'h00, 1, 8'hFF, 0);
    send(8'hFF, 1, 8'h00, 1);

    // Output stall for five cycles while locked.
    send_mark(32'hE53003E2);
    m_axis_tready = 1'b0;
    send(8'h10, 1, 8'hEF, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge core_clk);
      check("stall_s_tready", s_axis_tready, 0);
      check("stall_tdata", m_axis_tdata, 8'hEF);
    end
    @(posedge core_clk);
    #1;
    m_axis_tready = 1'b1;
    send(8'h20, 1, 8'hDF, 0);
    send(8'h30, 1, 8'hCF, 0);
    send(8'h40, 1, 8'hBF, 1);

    // Reset at position 2 of a locked frame.
    send_mark(32'hE53003E2);
    send(8'h01, 1, 8'hFE, 0);
    send(8'h02, 1, 8'hFD, 0);
    @(posedge core_clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_tvalid", m_axis_tvalid, 0);
    check("midrst_tlast", m_axis_tlast, 0);
    check("midrst_locked", locked, 0);
    check("midrst_inverted", inverted, 0);
    @(posedge core_clk);
    #1;
    rst = 1'b0;

    // Relock after reset, with single-bit-error markers accepted and a two-bit one rejected.
    send_mark(32'h1ACFFC1C);
    send_quiet(32'h01020304);
    send_mark(32'h1ACFFC1E);
    check("twobit_not_locked", locked, 0);
    check("twobit_no_loss", sync_loss, 0);
    send_mark(32'h1ACFFC1D);
    check("relock_needs_two", locked, 0);
    send_quiet(32'h05060708);
    send_mark(32'h1ACFFC1C);
    check("onebit_locked", locked, 1);
    send(8'h09, 1, 8'h09, 0);
    send(8'h0A, 1, 8'h0A, 0);
    send(8'h0B, 1, 8'h0B, 0);
    send(8'h0C, 1, 8'h0C, 1);

    repeat (4) @(posedge core_clk);
    #1;
    check("all_outputs_seen", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
